// File: rtl/bit_frame_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
// BIT_FRAME_TX_PARITY_EN adds an even-parity bit, making frames 11 bits long.
package bit_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef BIT_FRAME_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/bit_frame_tx_if.sv
// Request/line bundle between a word source and bit_frame_tx.
// Handshake: a word is taken on the rising edge where start=1 and ready=1; start
// while ready=0 is dropped, and done pulses for the last cycle of the stop bit.
interface bit_frame_tx_if;
  import bit_frame_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 start;
  logic                 tx;
  logic                 ready;
  logic                 busy;
  logic                 done;
  tx_state_t            dbg_state;

  modport master (
    output data, start,
    input  tx, ready, busy, done, dbg_state
  );

  modport slave (
    input  data, start,
    output tx, ready, busy, done, dbg_state
  );

endinterface

// File: rtl/bit_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 and pulses tick in the wrap cycle.
// clr holds the count at zero so a new frame starts on a clean period.
module bit_timer #(
  parameter int DIV = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;
  logic          at_top;

  assign at_top = (cnt_q == CW'(DIV - 1));
  assign tick   = at_top && !clr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (at_top) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bit_frame_tx.sv
// Parallel-in serial-out async frame transmitter: start, 8 data, [parity], stop.
// Optional parity bit is enabled with the BIT_FRAME_TX_PARITY_EN macro.
module bit_frame_tx
  import bit_frame_pkg::*;
#(
  parameter int DIV       = 5208,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  bit_frame_tx_if.slave    bus
);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [2:0]           idx_q, idx_d;
  logic                 tick;
  logic                 tx_c;
`ifdef BIT_FRAME_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Timer is held cleared while idle, so the START bit gets a full period.
  bit_timer #(.DIV(DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
`ifdef BIT_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
`ifdef BIT_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
`ifdef BIT_FRAME_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = bus.data;
          idx_d   = '0;
          state_d = START;
`ifdef BIT_FRAME_TX_PARITY_EN
          par_d   = ^bus.data;
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          sr_d  = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef BIT_FRAME_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef BIT_FRAME_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_c = 1'b1;
    case (state_q)
      START:  tx_c = 1'b0;
      DATA:   tx_c = (MSB_FIRST != 0) ? sr_q[DATA_BITS-1] : sr_q[0];
`ifdef BIT_FRAME_TX_PARITY_EN
      PARITY: tx_c = par_q;
`endif
      default: tx_c = 1'b1;
    endcase
  end

  assign bus.tx        = tx_c;
  assign bus.ready     = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == STOP) && tick;
  assign bus.dbg_state = state_q;

endmodule
